// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ROUND,
      DONE
   } state_e;

   typedef enum logic [2:0] {
      ZERO,
      PM,
      P2M,
      M2M,
      MM
   } booth_sel_e;

   localparam int SAT_MAX_W = 64;

   typedef struct packed {
      logic [SAT_MAX_W-1:0] pos;
      logic [SAT_MAX_W-1:0] neg;
   } sat_t;

   // Clamp values for a signed two's-complement word of the given width.
   function automatic sat_t sat_consts(input int unsigned width);
      sat_t s;
      s.neg = {{(SAT_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
      s.pos = s.neg - {{(SAT_MAX_W-1){1'b0}}, 1'b1};
      return s;
   endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// rtl/booth_r4_recoder.sv - radix-4 Booth digit recode and partial-product select
module booth_r4_recoder
   import booth_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [2:0]       q_bits,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH+1:0] pp
);

   booth_sel_e       sel;
   logic [WIDTH+1:0] m1;
   logic [WIDTH+1:0] m2;

   assign m1 = {{2{m[WIDTH-1]}}, m};
   assign m2 = {m[WIDTH-1], m, 1'b0};

   always_comb begin
      sel = ZERO;
      case (q_bits)
         3'b001, 3'b010: sel = PM;
         3'b011:         sel = P2M;
         3'b100:         sel = M2M;
         3'b101, 3'b110: sel = MM;
         default:        sel = ZERO;
      endcase
   end

   always_comb begin
      pp = '0;
      case (sel)
         PM:      pp = m1;
         P2M:     pp = m2;
         M2M:     pp = -m2;
         MM:      pp = -m1;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/carry_select_adder.sv
// rtl/carry_select_adder.sv - parametrised carry-select adder, wrap-around sum
module carry_select_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum
);

   if (WIDTH < 2) begin : g_small
      assign sum = a + b + WIDTH'(cin);
   end else begin : g_split
      localparam int LO  = WIDTH / 2;
      localparam int HI  = WIDTH - LO;
      localparam int LO1 = LO + 1;

      logic [LO:0]   lo_sum;
      logic [HI-1:0] hi_sum0;
      logic [HI-1:0] hi_sum1;

      // Upper half is precomputed for both carry values and picked by the low carry.
      assign lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + LO1'(cin);
      assign hi_sum0 = a[WIDTH-1:LO] + b[WIDTH-1:LO];
      assign hi_sum1 = a[WIDTH-1:LO] + b[WIDTH-1:LO] + HI'(1'b1);
      assign sum     = {(lo_sum[LO] ? hi_sum1 : hi_sum0), lo_sum[LO-1:0]};
   end

endmodule

// File: rtl/booth_multiplier_r4.sv
// rtl/booth_multiplier_r4.sv - iterative radix-4 Booth signed fixed-point multiplier
module booth_multiplier_r4
   import booth_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int FRAC     = 7,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic             round_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   localparam int              CW        = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
   localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH / 2 - 1);
   localparam int              RW        = 2 * WIDTH - FRAC;
   localparam sat_t            SAT       = sat_consts(WIDTH);
   localparam logic [WIDTH-1:0] SAT_POS  = SAT.pos[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SAT_NEG  = SAT.neg[WIDTH-1:0];

   state_e           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             round_q, round_d;
   logic [WIDTH+1:0] a_q, a_d;
   logic [WIDTH:0]   q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;

   logic [WIDTH+1:0] pp;
   logic [WIDTH+1:0] acc_sum;
   logic [CW-1:0]    cnt_inc;
   logic [RW-1:0]    rnd_sum;
   logic [WIDTH-FRAC:0] ovf_bits;
   logic             ovf;

   booth_r4_recoder #(.WIDTH(WIDTH)) u_recoder (
      .q_bits (q_q[2:0]),
      .m      (m_q),
      .pp     (pp)
   );

   carry_select_adder #(.WIDTH(WIDTH + 2)) u_loop_add (
      .a   (a_q),
      .b   (pp),
      .cin (1'b0),
      .sum (acc_sum)
   );

   carry_select_adder #(.WIDTH(CW)) u_cnt_add (
      .a   (cnt_q),
      .b   ('0),
      .cin (1'b1),
      .sum (cnt_inc)
   );

   // Adding half an LSB leaves bits below FRAC-1 untouched, so only the carry
   // out of product bit FRAC-1 reaches R[2W-1:FRAC].
   carry_select_adder #(.WIDTH(RW)) u_rnd_add (
      .a   ({a_q[WIDTH-1:0], q_q[WIDTH:FRAC+1]}),
      .b   ('0),
      .cin (round_q & q_q[FRAC]),
      .sum (rnd_sum)
   );

   assign ovf_bits = rnd_sum[RW-1:WIDTH-1];
   assign ovf      = !((&ovf_bits) || !(|ovf_bits));

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      round_d    = round_q;
      a_d        = a_q;
      q_d        = q_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               m_d     = multiplicand;
               round_d = round_en;
               a_d     = '0;
               q_d     = {multiplier, 1'b0};
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            a_d   = {acc_sum[WIDTH+1], acc_sum[WIDTH+1], acc_sum[WIDTH+1:2]};
            q_d   = {acc_sum[1:0], q_q[WIDTH:2]};
            cnt_d = cnt_inc;
            if (cnt_q == LAST_STEP) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            overflow_d = ovf;
            if (ovf && SATURATE) begin
               result_d = rnd_sum[RW-1] ? SAT_NEG : SAT_POS;
            end else begin
               result_d = rnd_sum[WIDTH-1:0];
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         m_q        <= '0;
         round_q    <= 1'b0;
         a_q        <= '0;
         q_q        <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         round_q    <= round_d;
         a_q        <= a_d;
         q_q        <= q_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign overflow  = overflow_q;

endmodule

// File: doc/booth_multiplier_r4.md
# booth_multiplier_r4

Parametrised signed fixed-point multiplier using iterative radix-4 Booth recoding. It retires two multiplier bits per cycle, rounds and optionally saturates the product back to the operand format, and flags overflow. It uses a valid/ready handshake on both sides. It is the datapath multiplier for the ODE-solver arithmetic units and takes over from the radix-2 start/finish multiplier.

## Interface
- WIDTH, 16: operand/result width in bits; must be even and ≥ 4.
- FRAC, 7: fraction bits of the signed fixed-point format; 1 ≤ FRAC < WIDTH.
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap (keep low bits).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; high only in IDLE.
- multiplicand  in  WIDTH  signed operand M.
- multiplier  in  WIDTH  signed operand Q.
- round_en  in  1  1 = round half-up, 0 = truncate; captured at accept.
- out_valid  out  1  result valid; held until it is taken.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  rounded, saturated or wrapped product.
- overflow  out  1  product exceeds the format; valid with out_valid.

## Operation
- States: IDLE, CALC, ROUND, DONE.
- IDLE → CALC on in_valid & in_ready. On that edge:
  - load M and round_en;
  - clear accumulator A (WIDTH+2 bits);
  - load Q register = {multiplier, 1'b0};
  - clear counter.
- CALC performs one step per cycle:
  - recode Q[2:0]: 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M;
  - add the selected partial product to A;
  - arithmetic-shift {A, Q} right by 2.
- CALC lasts exactly WIDTH/2 steps, then goes to ROUND.
- Full product P is 2·WIDTH bits, signed, taken from the low 2·WIDTH bits of the shifted {A, Q[WIDTH:1]}.
- ROUND:
  - R = P + (round_en ? 2^(FRAC−1) : 0), computed at 2·WIDTH bits; this cannot carry out.
  - overflow = R[2W−1 : W+FRAC−1] not all-equal.
  - result = R[W+FRAC−1 : FRAC] when there is no overflow, or when SATURATE = 0.
  - With SATURATE = 1 and overflow: result = 0111…1 if R is positive, 1000…0 if R is negative.
  - Register result and overflow; go to DONE.
- DONE: out_valid = 1; result and overflow stay stable. Go to IDLE on out_ready.
- in_valid is ignored outside IDLE. Operands and round_en may change freely after acceptance.
- Reset, in any state including mid-CALC: next state IDLE, any in-flight operation is discarded.
- Output reset values: in_ready = 1, out_valid = 0, result = 0, overflow = 0.

## Timing
- Acceptance edge = edge 0.
- CALC steps occupy edges 1 … WIDTH/2. ROUND registers the result at edge WIDTH/2+1.
- out_valid is high from edge WIDTH/2+1. For WIDTH = 16 that is edge 9.
- If out_ready is already high, out_valid is a one-cycle pulse. in_ready returns at edge WIDTH/2+2.
- Minimum initiation interval: WIDTH/2+2 cycles. No overlap between operations.
- out_ready low holds DONE indefinitely with the outputs unchanged.
- rst high with out_ready/in_valid in the same cycle: rst wins.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE/CALC/ROUND/DONE);
  - the Booth select encoding (ZERO, PM, P2M, M2M, MM);
  - a function returning the saturation constants for a given WIDTH.
- One sub-module, booth_r4_recoder: combinational. Takes Q[2:0] and M, returns the sign-extended WIDTH+2-bit partial product.
- The adders (loop, round, counter) use the team's carry_select_adder, parametrised to width.

## Test plan
(WIDTH = 16, FRAC = 7, SATURATE = 1 unless noted)
- 0x00C0 × 0x0100, round_en = 1 → result 0x0180, overflow 0; out_valid first seen at edge 9.
- 0xFF40 × 0x0100 → 0xFE80 (−3.0); 0x8000 × 0x8000 → 0x7FFF, overflow 1. With SATURATE = 0: 0x0000, overflow 1.
- 0x3200 × 0x0200 → 0x7FFF, overflow 1. 0xCE00 × 0x0200 → 0x8000, overflow 1.
- 0x0001 × 0x0040:
  - round_en = 1 → 0x0001;
  - round_en = 0 → 0x0000;
  - 0xFFFF × 0x0040, round_en = 1 → 0x0000.
- Hold out_ready low 20 cycles:
  - result, overflow and out_valid stay stable;
  - in_valid pulses are ignored;
  - release → in_ready high the next cycle.
- Assert rst at edge 4 of an operation → out_valid 0, in_ready 1. A new operation issued afterwards completes correctly.
